// File: rtl/rc4_pkg.sv
// rc4_pkg: shared byte width, FSM state encodings and FIFO pointer-width helper
package rc4_pkg;
  localparam int BYTE_W = 8;
  typedef logic [1:0] state_t;
  localparam state_t IDLE = 2'd0;
  localparam state_t RUN = 2'd1;
  localparam state_t FLUSH = 2'd2;
  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction
endpackage

// File: rtl/rc4_ks_fifo.sv
// rc4_ks_fifo: single-clock first-word-fall-through keystream byte FIFO (push/din in, pop/dout head out, full/empty flags)
module rc4_ks_fifo
  import rc4_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
  input  logic [BYTE_W-1:0] din,
  output logic [BYTE_W-1:0] dout,
  output logic              full,
  output logic              empty
);
  localparam int AW = ptr_w(DEPTH);
  logic [AW:0] wr, rd;
  logic [BYTE_W-1:0] mem [DEPTH];
  assign dout = mem[rd[AW-1:0]];
  assign empty = wr == rd;
  assign full = (wr[AW] != rd[AW]) && (wr[AW-1:0] == rd[AW-1:0]);
  always_ff @(posedge clk)
    if (push) mem[wr[AW-1:0]] <= din;
  always_ff @(posedge clk)
    if (!rst_n) begin
      wr <= '0;
      rd <= '0;
    end else begin
      if (push) wr <= wr + (AW+1)'(1);
      if (pop) rd <= rd + (AW+1)'(1);
    end
endmodule

// File: rtl/rc4_stream_xor.sv
// rc4_stream_xor: buffers RC4 keystream and XORs it byte-for-byte with a data stream (start/msg_len, ks_*, in_*, out_*, busy/done/ks_overflow/byte_count)
module rc4_stream_xor
  import rc4_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int LEN_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [LEN_W-1:0]  msg_len,
  input  logic              ks_valid,
  input  logic [BYTE_W-1:0] ks_byte,
  output logic              ks_ready,
  input  logic              in_valid,
  input  logic [BYTE_W-1:0] in_byte,
  output logic              in_ready,
  output logic              out_valid,
  output logic [BYTE_W-1:0] out_byte,
  input  logic              out_ready,
  output logic              busy,
  output logic              done,
  output logic              ks_overflow,
  output logic [LEN_W-1:0]  byte_count
);
  state_t state;
  logic [LEN_W-1:0] len;
  logic [BYTE_W-1:0] head;
  logic full, empty, push, pop, xfer, go, out_hs;
  assign busy = state != IDLE;
  assign ks_ready = !full;
  assign in_ready = state == RUN && !empty && (!out_valid || out_ready);
  assign xfer = in_valid && in_ready;
  assign pop = xfer;
  // a full FIFO still accepts a byte when the head leaves in the same cycle
  assign push = ks_valid && (!full || pop);
  assign go = start && state == IDLE;
  assign out_hs = out_valid && out_ready;
  rc4_ks_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .rst_n(rst_n),
    .push(push),
    .pop(pop),
    .din(ks_byte),
    .dout(head),
    .full(full),
    .empty(empty)
  );
  always_ff @(posedge clk)
    if (!rst_n) begin
      state <= IDLE;
      len <= '0;
      out_valid <= 1'b0;
      out_byte <= '0;
      done <= 1'b0;
      ks_overflow <= 1'b0;
      byte_count <= '0;
    end else begin
      done <= (go && msg_len == '0) || (state == FLUSH && out_hs);
      ks_overflow <= (ks_valid && full && !pop) || (ks_overflow && !go);
      out_valid <= xfer || (out_valid && !out_ready);
      if (xfer) begin
        out_byte <= in_byte ^ head;
        byte_count <= byte_count + LEN_W'(1);
      end
      if (go) begin
        byte_count <= '0;
        len <= msg_len;
        state <= msg_len == '0 ? IDLE : RUN;
      end else if (xfer && byte_count == len - LEN_W'(1)) state <= FLUSH;
      else if (state == FLUSH && out_hs) state <= IDLE;
    end
endmodule

// File: tb/tb_rc4_stream_xor.sv
// tb_rc4_stream_xor: directed self-checking bench for rc4_stream_xor
module tb_rc4_stream_xor;
  logic clk = 0, rst_n = 0, start = 0, ks_valid = 0, in_valid = 0, out_ready = 0;
  logic [15:0] msg_len = '0;
  logic [7:0] ks_byte = '0, in_byte = '0;
  logic ks_ready, in_ready, out_valid, busy, done, ks_overflow;
  logic [7:0] out_byte;
  logic [15:0] byte_count;
  int n_checks = 0, n_fails = 0;
  rc4_stream_xor #(.DEPTH(8), .LEN_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .msg_len(msg_len),
    .ks_valid(ks_valid), .ks_byte(ks_byte), .ks_ready(ks_ready),
    .in_valid(in_valid), .in_byte(in_byte), .in_ready(in_ready),
    .out_valid(out_valid), .out_byte(out_byte), .out_ready(out_ready),
    .busy(busy), .done(done), .ks_overflow(ks_overflow), .byte_count(byte_count)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #2;
  endtask
  task automatic push_ks(input logic [7:0] b);
    ks_valid = 1;
    ks_byte = b;
    tick();
    ks_valid = 0;
  endtask
  task automatic kick(input logic [15:0] n);
    start = 1;
    msg_len = n;
    tick();
    start = 0;
  endtask
  initial begin
    logic [7:0] ks3 [3] = '{8'hA5, 8'h3C, 8'hFF};
    logic [7:0] in3 [3] = '{8'h00, 8'h11, 8'h22};
    logic [7:0] ex3 [3] = '{8'hA5, 8'h2D, 8'hDD};
    #2;
    for (int i = 0; i < 3; i++) begin
      ks_valid = i[0];
      ks_byte = 8'hE0 + 8'(i);
      tick();
    end
    ks_valid = 0;
    tick();
    rst_n = 1;
    #1;
    check("rst out_valid", out_valid, 0);
    check("rst out_byte", out_byte, 0);
    check("rst busy", busy, 0);
    check("rst done", done, 0);
    check("rst ks_overflow", ks_overflow, 0);
    check("rst byte_count", byte_count, 0);
    check("rst ks_ready", ks_ready, 1);
    check("rst in_ready", in_ready, 0);
    for (int i = 0; i < 3; i++) push_ks(ks3[i]);
    kick(3);
    check("basic busy", busy, 1);
    check("basic count0", byte_count, 0);
    in_valid = 1;
    out_ready = 1;
    for (int i = 0; i < 3; i++) begin
      in_byte = in3[i];
      #1;
      check("basic in_ready", in_ready, 1);
      tick();
      check("basic out_valid", out_valid, 1);
      check("basic out_byte", out_byte, ex3[i]);
      check("basic done early", done, 0);
    end
    in_valid = 0;
    #1;
    check("flush in_ready", in_ready, 0);
    check("basic count", byte_count, 3);
    tick();
    check("basic done", done, 1);
    check("basic busy end", busy, 0);
    check("basic out_valid end", out_valid, 0);
    tick();
    check("basic done once", done, 0);
    check("basic count held", byte_count, 3);
    for (int i = 1; i <= 4; i++) push_ks(8'(i * 16));
    kick(4);
    in_valid = 1;
    in_byte = 8'h01;
    tick();
    check("bp first", out_byte, 8'h11);
    out_ready = 0;
    in_byte = 8'h02;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("bp in_ready", in_ready, 0);
      tick();
      check("bp hold byte", out_byte, 8'h11);
      check("bp hold valid", out_valid, 1);
      check("bp count", byte_count, 1);
    end
    out_ready = 1;
    for (int i = 2; i <= 4; i++) begin
      in_byte = 8'(i);
      #1;
      check("bp resume ready", in_ready, 1);
      tick();
      check("bp out_byte", out_byte, 8'(i * 17));
    end
    in_valid = 0;
    tick();
    check("bp done", done, 1);
    check("bp count", byte_count, 4);
    kick(1);
    in_valid = 1;
    in_byte = 8'hF0;
    #1;
    check("starve in_ready", in_ready, 0);
    tick();
    check("starve out_valid", out_valid, 0);
    ks_valid = 1;
    ks_byte = 8'h5A;
    tick();
    ks_valid = 0;
    #1;
    check("starve ready after push", in_ready, 1);
    tick();
    check("starve out_byte", out_byte, 8'hAA);
    check("starve out_valid", out_valid, 1);
    in_valid = 0;
    tick();
    check("starve done", done, 1);
    for (int i = 1; i <= 9; i++) begin
      push_ks(8'(i));
      if (i == 8) begin
        check("ovf ks_ready full", ks_ready, 0);
        check("ovf not yet", ks_overflow, 0);
      end
    end
    check("ovf sticky", ks_overflow, 1);
    tick();
    check("ovf held", ks_overflow, 1);
    kick(8);
    check("ovf cleared by start", ks_overflow, 0);
    in_valid = 1;
    in_byte = 8'h00;
    for (int i = 1; i <= 8; i++) begin
      tick();
      check("ovf contents", out_byte, 8'(i));
    end
    in_valid = 0;
    check("ovf ks_ready drained", ks_ready, 1);
    tick();
    check("ovf done", done, 1);
    kick(0);
    check("zero done", done, 1);
    check("zero out_valid", out_valid, 0);
    check("zero busy", busy, 0);
    tick();
    check("zero done once", done, 0);
    push_ks(8'h77);
    push_ks(8'h88);
    kick(2);
    in_valid = 1;
    tick();
    check("ign first", out_byte, 8'h77);
    in_valid = 0;
    kick(5);
    check("ign count", byte_count, 1);
    check("ign busy", busy, 1);
    in_valid = 1;
    tick();
    check("ign second", out_byte, 8'h88);
    check("ign count2", byte_count, 2);
    in_valid = 0;
    tick();
    check("ign done on old length", done, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule

// File: doc/rc4_stream_xor.md
Name: rc4_stream_xor

Overview:
- Downstream consumer of the RC4 keystream generator.
- Buffers keystream bytes in a small FIFO and XORs them one-for-one with a plaintext/ciphertext byte stream.
- Emits the result on a valid/ready output.
- Counts bytes against a programmed message length and signals completion; encrypt and decrypt are the same operation.

Parameters:
- DEPTH, 8, keystream FIFO depth in bytes; power of two, at least 2.
- LEN_W, 16, width of message length and byte counter.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset
- start  in  1  single-cycle pulse; begins a message; ignored while busy=1
- msg_len  in  LEN_W  bytes in the message; sampled on accepted start
- ks_valid  in  1  keystream byte present this cycle; the generator cannot stall
- ks_byte  in  8  keystream byte
- ks_ready  out  1  FIFO not full; advisory to the generator
- in_valid  in  1  input data byte valid
- in_byte  in  8  plaintext or ciphertext byte
- in_ready  out  1  input byte accepted this cycle when in_valid=1
- out_valid  out  1  result byte valid
- out_byte  out  8  in_byte XOR keystream byte
- out_ready  in  1  downstream accepts out_byte
- busy  out  1  message in progress
- done  out  1  single-cycle pulse at end of message
- ks_overflow  out  1  sticky; keystream byte was dropped
- byte_count  out  LEN_W  bytes accepted in the current message

Behaviour:
- Reset: rst_n is synchronous, active-low; clock clk.
  - Reset values: state IDLE, FIFO empty, out_valid=0, out_byte=0, busy=0, done=0, ks_overflow=0, byte_count=0, ks_ready=1, in_ready=0.
  - Reset mid-message drops all buffered data; no done pulse is produced.
- Keystream FIFO push:
  - Push occurs on ks_valid in every state, including IDLE, so keystream produced before start is retained.
  - The FIFO is cleared only by reset.
  - Full with no pop in the same cycle: the byte is dropped and ks_overflow is set.
  - Full with a pop in the same cycle: push is legal and no overflow occurs.
  - ks_overflow is cleared by an accepted start.
  - Read and write pointers are LEN-independent, log2(DEPTH)+1 bits wide, and wrap naturally.
- FSM states:
  - IDLE: accepted start with msg_len=0 gives a done pulse on the next cycle and stays in IDLE. Otherwise go to RUN, set busy=1, load the length, clear byte_count.
  - RUN: the transfer condition xfer = in_valid & in_ready applies.
    - in_ready = FIFO not empty & (out_valid=0 | out_ready=1).
    - On xfer: pop the FIFO head, out_byte <= in_byte ^ head, out_valid <= 1, byte_count += 1.
    - On the xfer where byte_count == msg_len-1: go to FLUSH.
  - FLUSH: in_ready=0. When out_valid & out_ready: clear out_valid, pulse done on the next cycle, set busy=0, return to IDLE.
- Output register:
  - out_valid clears on out_ready unless a new xfer occurs in the same cycle.
  - out_byte is held stable while out_valid=1 and out_ready=0.
- Timing:
  - Latency is 1 cycle from input handshake to out_valid.
  - Throughput is 1 byte/cycle when the FIFO is non-empty and out_ready=1.
- Starvation: FIFO empty means in_ready=0; no byte is ever combined with stale keystream.
- byte_count is held after done until the next accepted start.

Decomposition:
- Shared package rc4_pkg:
  - BYTE_W=8.
  - State enum (IDLE, RUN, FLUSH).
  - Localparam helper for pointer width, $clog2(DEPTH).
- Sub-module rc4_ks_fifo: synchronous single-clock byte FIFO.
  - Ports: push, pop, din, dout (head, first-word fall-through), full, empty.
  - Overflow detection stays in the parent.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with ks_valid toggling. Required: all outputs at reset values, ks_ready=1, FIFO empty afterwards.
- Basic message, msg_len=3:
  - Stimulus: push keystream A5,3C,FF; send input 00,11,22 with out_ready=1.
  - Required: out_byte A5,2D,DD on consecutive cycles; done pulses exactly once, 1 cycle after the last out handshake; byte_count=3.
- Output backpressure: out_ready=0 for 4 cycles mid-message. Required: in_ready=0, out_byte stable; with out_ready=1 transfer resumes and no byte is lost or duplicated.
- Keystream starvation: FIFO empty, in_valid=1. Required: in_ready=0. Push one byte 5A with in_byte F0: out_byte=AA on the following cycle.
- Overflow, DEPTH=8, no consumption:
  - Stimulus: push 01..09.
  - Required: ks_ready=0 after the 8th push, ks_overflow=1 on the 9th, FIFO holds 01..08.
  - A subsequent start clears ks_overflow.
- Zero length and ignored start:
  - start with msg_len=0: done pulses on the next cycle, out_valid stays 0.
  - start pulsed while busy: no change to byte_count or length.
